// File: rtl/add_sub_arb_pkg.sv
// Shared types, constants and helpers for the shared add/sub arbiter.
// Stage records are sized for the widest supported operand (MAX_WIDTH) and ID.
package add_sub_arb_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int MAX_ID_W  = 3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [MAX_ID_W-1:0]  id;
    logic [MAX_WIDTH-1:0] result;
    logic                 cout;
    logic                 overflow;
  } stage_t;

  function automatic int calc_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the last accepted requester plus one and
// only moves its pointer when the caller reports an accepted transfer.
module rr_arbiter
  import add_sub_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = calc_id_w(NUM_REQ)
) (
  input  logic               clock,
  input  logic               sclr,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_accept,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any
);

  logic [ID_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W-1:0]    w_probe;
  logic               w_found;
  int                 w_idx;

  // Reset value makes requester 0 the first one searched.
  always_ff @(posedge clock) begin
    if (sclr) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (i_accept) begin
      r_ptr <= w_grant_idx;
    end
  end

  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = 0;
    w_probe     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      w_probe = ID_W'(w_idx);
      if (!w_found && i_req[w_probe]) begin
        w_found          = 1'b1;
        w_grant[w_probe] = 1'b1;
        w_grant_idx      = w_probe;
      end
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_grant_idx;
  assign o_any       = w_found;

endmodule

// File: rtl/add_sub_arbiter.sv
// Shares one pipelined adder/subtractor between NUM_REQ valid/ready requesters;
// results leave in acceptance order on a single backpressured response port.
module add_sub_arbiter
  import add_sub_arb_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_REQ   = 4,
  parameter int PIPE      = 2,
  parameter int SIGNED_OV = 1,
  parameter int ID_W      = calc_id_w(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       sclr,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_dataa,
  input  logic [NUM_REQ*WIDTH-1:0]   req_datab,
  input  logic [NUM_REQ-1:0]         req_sub,
  input  logic [NUM_REQ-1:0]         req_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       rsp_cout,
  output logic                       rsp_overflow,
  output logic [$clog2(PIPE+1):0]    inflight
);

  localparam int IF_W = $clog2(PIPE + 1) + 1;

  stage_t              r_stage [PIPE];
  stage_t              w_new;
  logic                w_advance;
  logic                w_accept;
  logic                w_any;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gidx;
  logic [WIDTH-1:0]    w_a;
  logic [WIDTH-1:0]    w_b;
  logic [WIDTH-1:0]    w_b_eff;
  logic                w_sub;
  logic                w_cin;
  logic [WIDTH:0]      w_sum;
  logic [IF_W-1:0]     w_count;
  logic                w_unused_bits;

  assign w_advance = !r_stage[PIPE-1].valid || rsp_ready;
  assign req_ready = (w_advance && !sclr) ? w_grant : '0;
  assign w_accept  = w_advance && !sclr && w_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clock       (clock),
    .sclr        (sclr),
    .i_req       (req_valid),
    .i_accept    (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx),
    .o_any       (w_any)
  );

  assign w_a     = req_dataa[int'(w_gidx)*WIDTH +: WIDTH];
  assign w_b     = req_datab[int'(w_gidx)*WIDTH +: WIDTH];
  assign w_sub   = req_sub[w_gidx];
  assign w_cin   = req_cin[w_gidx];
  assign w_b_eff = (w_sub == OP_SUB) ? ~w_b : w_b;
  assign w_sum   = {1'b0, w_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

  // Subtract overflow is the add rule applied to the inverted B operand.
  always_comb begin
    w_new = '0;
    if (w_accept) begin
      w_new.valid  = 1'b1;
      w_new.id     = MAX_ID_W'(w_gidx);
      w_new.result = MAX_WIDTH'(w_sum[WIDTH-1:0]);
      w_new.cout   = w_sum[WIDTH];
      if (SIGNED_OV != 0) begin
        w_new.overflow = (w_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end else begin
        w_new.overflow = (w_sub == OP_SUB) ? !w_sum[WIDTH] : w_sum[WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      for (int k = 0; k < PIPE; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_advance) begin
      r_stage[0] <= w_new;
      for (int k = 1; k < PIPE; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < PIPE; k++) begin
      w_count = w_count + IF_W'(r_stage[k].valid);
    end
  end

  assign inflight     = w_count;
  assign rsp_valid    = r_stage[PIPE-1].valid;
  assign rsp_id       = r_stage[PIPE-1].id[ID_W-1:0];
  assign rsp_result   = r_stage[PIPE-1].result[WIDTH-1:0];
  assign rsp_cout     = r_stage[PIPE-1].cout;
  assign rsp_overflow = r_stage[PIPE-1].overflow;

  // Upper record bits beyond WIDTH/ID_W are always zero.
  assign w_unused_bits = ^r_stage[PIPE-1];

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Self-checking bench for add_sub_arbiter: directed scenarios plus a random run,
// all cross-checked every cycle against a queue-based behavioural model.
module tb_add_sub_arbiter;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int P    = 2;
  localparam int SOV  = 1;
  localparam int IDW  = 2;
  localparam int IFW  = $clog2(P + 1) + 1;

  logic             clock;
  logic             sclr;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_dataa;
  logic [N*W-1:0]   req_datab;
  logic [N-1:0]     req_sub;
  logic [N-1:0]     req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_result;
  logic             rsp_cout;
  logic             rsp_overflow;
  logic [IFW-1:0]   inflight;

  int errors = 0;
  int checks = 0;
  bit monOn  = 1'b0;

  typedef struct {
    int          id;
    logic [W-1:0] res;
    logic        cout;
    logic        ov;
    int          cnt;
  } exp_t;

  exp_t expQ[$];
  int   modelPtr = N - 1;

  add_sub_arbiter #(
    .WIDTH(W), .NUM_REQ(N), .PIPE(P), .SIGNED_OV(SOV)
  ) dut (
    .clock(clock), .sclr(sclr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dataa(req_dataa), .req_datab(req_datab),
    .req_sub(req_sub), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
    .inflight(inflight)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Arithmetic reference computed from integer values, not bit tricks.
  function automatic exp_t model_op(int id, logic [W-1:0] a, logic [W-1:0] b,
                                    logic sub, logic cin);
    exp_t   e;
    longint ua, ub, full, sum, sa, sb, tv;
    ua   = longint'(a);
    ub   = longint'(b);
    full = longint'(1) << W;
    if (sub) sum = ua + (full - 1 - ub) + longint'(cin);
    else     sum = ua + ub + longint'(cin);
    e.id   = id;
    e.res  = W'(sum % full);
    e.cout = (sum >= full);
    sa = (ua >= full / 2) ? ua - full : ua;
    sb = (ub >= full / 2) ? ub - full : ub;
    if (sub) tv = sa - sb - (1 - longint'(cin));
    else     tv = sa + sb + longint'(cin);
    if (SOV != 0) e.ov = (tv < -(full / 2)) || (tv > full / 2 - 1);
    else          e.ov = sub ? !e.cout : e.cout;
    e.cnt = P - 1;
    return e;
  endfunction

  // Scoreboard: compares mid-cycle, then advances the model for the next edge.
  always @(negedge clock) begin : scoreboard
    logic         expValid;
    logic         adv;
    logic [N-1:0] expReady;
    int           g;
    int           idx;
    exp_t         e;
    expValid = (expQ.size() > 0) && (expQ[0].cnt == 0);
    adv      = !expValid || rsp_ready;
    g        = -1;
    if (!sclr && adv) begin
      for (int k = 1; k <= N; k++) begin
        idx = (modelPtr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    expReady = (g >= 0) ? N'(1 << g) : '0;
    if (monOn) begin
      checks++;
      if (req_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL sb_req_ready t=%0t got=%b exp=%b", $time, req_ready, expReady);
      end
      checks++;
      if (rsp_valid !== expValid) begin
        errors++;
        $display("[TB] FAIL sb_rsp_valid t=%0t got=%b exp=%b", $time, rsp_valid, expValid);
      end
      checks++;
      if (inflight !== IFW'(expQ.size())) begin
        errors++;
        $display("[TB] FAIL sb_inflight t=%0t got=%0d exp=%0d", $time, inflight, expQ.size());
      end
      if (expValid) begin
        checks++;
        if ({rsp_id, rsp_result, rsp_cout, rsp_overflow} !==
            {IDW'(expQ[0].id), expQ[0].res, expQ[0].cout, expQ[0].ov}) begin
          errors++;
          $display("[TB] FAIL sb_payload t=%0t got id=%0d res=%h c=%b ov=%b exp id=%0d res=%h c=%b ov=%b",
                   $time, rsp_id, rsp_result, rsp_cout, rsp_overflow,
                   expQ[0].id, expQ[0].res, expQ[0].cout, expQ[0].ov);
        end
      end
    end
    if (sclr) begin
      expQ.delete();
      modelPtr = N - 1;
    end else if (adv) begin
      if (expValid) void'(expQ.pop_front());
      foreach (expQ[i]) if (expQ[i].cnt > 0) expQ[i].cnt--;
      if (g >= 0) begin
        e = model_op(g, req_dataa[g*W +: W], req_datab[g*W +: W], req_sub[g], req_cin[g]);
        expQ.push_back(e);
        modelPtr = g;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b, logic sub, logic cin);
    req_dataa[i*W +: W] = a;
    req_datab[i*W +: W] = b;
    req_sub[i]          = sub;
    req_cin[i]          = cin;
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < N; i++) begin
      set_op(i, pick_val(), pick_val(), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (P + 2) tick();
  endtask

  task automatic test_reset();
    sclr      = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    randomize_ops();
    @(negedge clock);
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("[TB] FAIL reset_req_ready got=%b exp=0", req_ready);
    end
    tick();
    sclr      = 1'b0;
    req_valid = '0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_rsp got v=%b id=%0d res=%h c=%b ov=%b exp all 0",
               rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow);
    end
    checks++;
    if (inflight !== '0) begin
      errors++;
      $display("[TB] FAIL reset_inflight got=%0d exp=0", inflight);
    end
    monOn = 1'b1;
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    set_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow} !==
        {1'b1, 2'd0, 16'h8000, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL single_add got v=%b id=%0d res=%h c=%b ov=%b exp v=1 id=0 res=8000 c=0 ov=1",
               rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow);
    end
    tick();
  endtask

  task automatic test_sub();
    rsp_ready = 1'b1;
    set_op(2, 16'h0005, 16'h0007, 1'b1, 1'b1);
    req_valid = 4'b0100;
    tick();
    set_op(2, 16'h0005, 16'h0007, 1'b1, 1'b0);
    tick();
    req_valid = '0;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow} !==
        {1'b1, 2'd2, 16'hFFFE, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sub_cin1 got v=%b id=%0d res=%h c=%b ov=%b exp v=1 id=2 res=fffe c=0 ov=0",
               rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow} !==
        {1'b1, 2'd2, 16'hFFFD, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sub_cin0 got v=%b id=%0d res=%h c=%b ov=%b exp v=1 id=2 res=fffd c=0 ov=0",
               rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow);
    end
    drain();
  endtask

  task automatic test_round_robin();
    sclr = 1'b1;
    tick();
    sclr      = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      randomize_ops();
      @(negedge clock);
      checks++;
      if (req_ready !== N'(1 << (k % N))) begin
        errors++;
        $display("[TB] FAIL rr_order k=%0d got=%b exp=%b", k, req_ready, N'(1 << (k % N)));
      end
      tick();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      randomize_ops();
      tick();
    end
    checks++;
    if (inflight !== IFW'(P) || rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_full got inflight=%0d v=%b exp inflight=%0d v=1", inflight, rsp_valid, P);
    end
    @(negedge clock);
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("[TB] FAIL stall_ready got=%b exp=0", req_ready);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL release_ready got=%b exp=0001", req_ready);
    end
    tick();
    checks++;
    if (inflight !== IFW'(P)) begin
      errors++;
      $display("[TB] FAIL release_inflight got=%0d exp=%0d", inflight, P);
    end
    drain();
    checks++;
    if (inflight !== '0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drained got inflight=%0d v=%b exp 0 0", inflight, rsp_valid);
    end
  endtask

  task automatic test_pair();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    randomize_ops();
    tick();
    req_valid = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      randomize_ops();
      @(negedge clock);
      checks++;
      if (req_ready !== ((k % 2 == 0) ? 4'b1000 : 4'b0010)) begin
        errors++;
        $display("[TB] FAIL pair_order k=%0d got=%b exp=%b", k, req_ready,
                 (k % 2 == 0) ? 4'b1000 : 4'b0010);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_mid_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    randomize_ops();
    tick();
    randomize_ops();
    tick();
    sclr      = 1'b1;
    req_valid = '1;
    @(negedge clock);
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_ready got=%b exp=0", req_ready);
    end
    tick();
    sclr = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || inflight !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_flush got v=%b inflight=%0d exp 0 0", rsp_valid, inflight);
    end
    @(negedge clock);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midreset_first_grant got=%b exp=0001", req_ready);
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      sclr      = ($urandom_range(0, 63) == 0);
      randomize_ops();
      tick();
    end
    sclr = 1'b0;
    drain();
  endtask

  initial begin
    sclr      = 1'b1;
    req_valid = '0;
    req_dataa = '0;
    req_datab = '0;
    req_sub   = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single_add();
    test_sub();
    test_round_robin();
    test_back_to_back();
    test_pair();
    test_mid_reset();
    test_random();
    monOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
- Shares one pipelined adder/subtractor between NUM_REQ requesters.
- Each requester has a valid/ready request port carrying operands, an add/sub select and a carry-in. Requests are granted round-robin.
- Every accepted operation travels down an internal PIPE-stage arithmetic pipeline with its requester ID. Results leave on one response port with backpressure.
- Sits between DSP operation clients (filters, accumulators) and the shared arithmetic resource.

Parameters:
- WIDTH, 16: operand and result width in bits; must be >= 1.
- NUM_REQ, 4: number of requesters; range 2..8.
- PIPE, 2: arithmetic latency in cycles; must be >= 1.
- SIGNED_OV, 1: 1 = overflow is signed two's-complement overflow; 0 = overflow is unsigned carry/borrow.
- ID_W, $clog2(NUM_REQ): requester ID width (derived).

Ports:
- clock, in, 1: rising-edge clock.
- sclr, in, 1: synchronous active-high reset.
- req_valid, in, NUM_REQ: request valid, one bit per requester.
- req_ready, out, NUM_REQ: request accepted when valid and ready are both 1.
- req_dataa, in, NUM_REQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_datab, in, NUM_REQ*WIDTH: operand B, packed the same way.
- req_sub, in, NUM_REQ: 1 = subtract, 0 = add.
- req_cin, in, NUM_REQ: carry-in for add; active-low borrow for subtract.
- rsp_valid, out, 1: response valid.
- rsp_ready, in, 1: downstream accepts the response.
- rsp_id, out, ID_W: index of the requester that issued the operation.
- rsp_result, out, WIDTH: result.
- rsp_cout, out, 1: carry-out (add) or no-borrow (subtract).
- rsp_overflow, out, 1: overflow flag; meaning set by SIGNED_OV.
- inflight, out, $clog2(PIPE+1)+1: number of valid operations held in the pipeline.

Behaviour:
- Reset: one clock, synchronous active-high (sclr).
  - While sclr is 1 (sampled at the edge): all stage valids clear, round-robin pointer = NUM_REQ-1 (requester 0 has first priority).
  - Outputs after reset: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0, rsp_overflow=0, inflight=0.
  - req_ready is 0 during the reset cycle.
  - sclr in mid-operation discards all in-flight operations; no response is produced for them.
- Pipeline advance: advance = !rsp_valid || rsp_ready. When advance=0 every stage holds its contents and req_ready is all zero.
- Arbitration:
  - Combinational grant goes to the first requester with req_valid=1, searching from pointer+1 modulo NUM_REQ.
  - req_ready[i] = advance && grant[i]. At most one bit is set. req_ready may depend on req_valid in the same cycle.
  - The pointer updates to the granted index only on an accepted transfer. It holds when there is no transfer or the pipeline is stalled.
- Arithmetic, computed at stage 1 on the accepted operands:
  - Add: {cout, result} = A + B + cin.
  - Subtract: {cout, result} = A + ~B + cin. With cin=1 this is A-B; with cin=0 it is A-B-1. cout = 1 means no borrow.
  - Signed overflow, add: A[msb] == B[msb] and result[msb] != A[msb].
  - Signed overflow, subtract: A[msb] != B[msb] and result[msb] != A[msb].
  - SIGNED_OV=0: add overflow = cout; subtract overflow = !cout.
  - Results wrap modulo 2^WIDTH.
- Latency: an operation accepted at edge T presents rsp_valid=1 after edge T+PIPE-1, i.e. visible in cycle T+PIPE. Each stall cycle adds one cycle.
- Throughput: one operation per cycle sustained while rsp_ready=1.
- Response hold: rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
- Ordering: responses come out in acceptance order; there is no reordering.
- inflight:
  - Equals the count of valid stage registers, including the output stage.
  - Rises by 1 on an accept, falls by 1 on a response handshake, and is unchanged when both happen in the same cycle.
- Boundaries:
  - No valid requester: no grant and no pointer change.
  - Pointer at NUM_REQ-1: the search wraps to requester 0.
  - A single requester held valid continuously is served every cycle.
  - Full pipeline with rsp_ready=0: no accepts (PIPE ops held, inflight=PIPE).
  - Stall released with a request pending: accept and response handshake happen in the same cycle.

Decomposition:
- Shared package add_sub_arb_pkg holds:
  - the stage record typedef (valid, id, result, cout, overflow);
  - the ID_W computation function;
  - opcode constants OP_ADD=0 and OP_SUB=1.
- One sub-module, rr_arbiter (NUM_REQ parameter), contains the request vector, pointer, accept strobe, one-hot grant and grant index.
- The arithmetic stage and delay line stay in the top level.

Test Plan:
- Single op, WIDTH=16, PIPE=2, req0 add 0x7FFF+0x0001, cin=0, rsp_ready=1 -> 2 cycles after accept: result=0x8000, cout=0, overflow=1 (SIGNED_OV=1), id=0.
- req2 subtract 0x0005-0x0007, cin=1 -> result=0xFFFE, cout=0, overflow=0; same with cin=0 -> result=0xFFFD.
- All four requesters valid continuously from reset -> grant order 0,1,2,3,0,1,…; one accept per cycle; rsp_id follows the same sequence.
- Back-to-back ops with rsp_ready low for 3 cycles:
  - inflight climbs to 2, req_ready=0, rsp_* stable;
  - release -> responses complete in order with no loss or duplication.
- Only req1 and req3 valid, pointer=1 -> grant req3, then req1, alternating; idle requesters never granted.
- sclr asserted with 2 ops in flight -> next cycle rsp_valid=0, inflight=0; the first post-reset grant goes to requester 0; the discarded ops never appear.
